regfile_scoreboard: RTL
=======================

// Module: regfile_scoreboard
// PURPOSE
//   Parametrised register file: DEPTH x DATA_W, two registered read ports, one write port.
//   Adds a per-register pending scoreboard that stalls consumers of multi-cycle results.
//   Adds optional write-to-read bypass and an optional hardwired-zero register 0.
//   Sits between decode (read addresses, reserve) and writeback (write port) in the datapath.
// PARAMETERS
//   DATA_W    8   register width in bits
//   DEPTH     4   number of registers, >= 2; need not be a power of two
//   BYPASS    0   1: a read in the same cycle as a write to that register returns write_data
//   ZERO_REG  0   1: register 0 always reads 0, ignores writes, is never pending
//   ADDR_W is derived as $clog2(DEPTH); it is not a parameter.
// PORTS
//   clk             in   1        rising-edge clock
//   reset           in   1        asynchronous, active-high reset
//   read_reg1       in   ADDR_W   read port 1 address
//   read_reg2       in   ADDR_W   read port 2 address
//   write           in   1        write enable
//   write_reg       in   ADDR_W   write address
//   write_data      in   DATA_W   write data
//   reserve         in   1        mark reserve_reg pending (multi-cycle producer issued)
//   reserve_reg     in   ADDR_W   register to reserve
//   read_data1      out  DATA_W   registered read data, port 1
//   read_data2      out  DATA_W   registered read data, port 2
//   read_pending1   out  1        registered pending flag matching read_data1
//   read_pending2   out  1        registered pending flag matching read_data2
//   any_pending     out  1        OR of all pending bits (from the flops, no extra delay)
// BEHAVIOUR
//   Reset: while reset=1, all registers, all pending bits, both read_data and both read_pending are 0.
//     Reset mid-operation discards every write and reservation in flight.
//   Write: at posedge clk, if write=1 and write_reg<DEPTH, regs[write_reg] <= write_data and pending[write_reg] <= 0.
//     If ZERO_REG=1 and write_reg=0, the write is ignored.
//   Reserve: at posedge clk, if reserve=1 and reserve_reg<DEPTH, pending[reserve_reg] <= 1.
//     If ZERO_REG=1 and reserve_reg=0, the reservation is ignored.
//     Reserve and write to the same register in the same cycle: data is written and the pending bit ends at 1
//     (the new producer wins).
//   Read: 1-cycle latency. read_dataN and read_pendingN are updated every posedge clk; there is no read enable.
//     BYPASS=0: outputs take the pre-edge regs and pending values; a same-cycle write is not visible.
//     BYPASS=1: if write targets read_regN with a valid write, read_dataN <= write_data and
//       read_pendingN <= (reserve && reserve_reg==read_regN). Otherwise the BYPASS=0 rule applies.
//     Both ports may read the same address. Either port may equal write_reg; each resolves independently.
//     read_regN >= DEPTH: read_dataN <= 0 and read_pendingN <= 0.
//     ZERO_REG=1 and read_regN=0: read_dataN <= 0 and read_pendingN <= 0, regardless of bypass.
//   Width: no arithmetic is performed. Data is stored and returned bit-exact.
// STRUCTURE
//   Package rf_pkg holds:
//     - the rf_addr_t and rf_data_t typedefs, parametrised through localparams for the defaults;
//     - the constant RF_ZERO_IDX = 0.
//   Sub-module rf_read_port holds the address mux, range check, zero-reg check, bypass compare and output flops.
//     It is instantiated twice.
//   Storage, write logic and the scoreboard stay in the top level.
// TESTING (defaults unless noted)
//   1. Pulse reset during traffic; write r2=8'hA5 the next cycle; read r2 the cycle after
//      -> all outputs 0 during reset; read_data1=8'hA5 one cycle after the read.
//   2. BYPASS=0 and BYPASS=1 builds: write r1=8'h3C while read_reg1=1
//      -> BYPASS=0 returns the old value 8'h00 next cycle; BYPASS=1 returns 8'h3C next cycle.
//   3. Reserve r3; read r3 next cycle; then write r3=8'h7E
//      -> read_pending1=1 and any_pending=1; after the write, read_pending1=0 and any_pending=0.
//   4. Reserve r1 and write r1=8'h11 in the same cycle
//      -> r1 holds 8'h11 and pending[1]=1 (reading r1 gives read_pending=1, any_pending=1).
//   5. ZERO_REG=1: write r0=8'hFF and reserve r0
//      -> read r0 gives 8'h00, read_pending=0, any_pending=0.
//   6. DEPTH=5, ADDR_W=3: write addr 6 = 8'h99; read addr 6 and addr 4
//      -> addr 6 reads 0 and no register changes; addr 4 returns its last written value.

Source files
------------

// File: rtl/regfile_scoreboard_pkg.sv
// Shared types and constants for the register file with pending scoreboard.
// Typedefs describe the default build; parametrised instances size their own vectors.
package rf_pkg;

    localparam int RF_DATA_W   = 8;
    localparam int RF_DEPTH    = 4;
    localparam int RF_ADDR_W   = $clog2(RF_DEPTH);
    localparam int RF_ZERO_IDX = 0;

    typedef logic [RF_ADDR_W-1:0] rf_addr_t;
    typedef logic [RF_DATA_W-1:0] rf_data_t;

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback side signals of the register file, grouped as one bundle.
// master drives addresses and write/reserve requests; slave is the register file.
interface regfile_scoreboard_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
);

    localparam int ADDR_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] read_reg1;
    logic [ADDR_W-1:0] read_reg2;
    logic              write;
    logic [ADDR_W-1:0] write_reg;
    logic [DATA_W-1:0] write_data;
    logic              reserve;
    logic [ADDR_W-1:0] reserve_reg;
    logic [DATA_W-1:0] read_data1;
    logic [DATA_W-1:0] read_data2;
    logic              read_pending1;
    logic              read_pending2;
    logic              any_pending;

    modport master (
        output read_reg1, read_reg2,
        output write, write_reg, write_data,
        output reserve, reserve_reg,
        input  read_data1, read_data2,
        input  read_pending1, read_pending2,
        input  any_pending
    );

    modport slave (
        input  read_reg1, read_reg2,
        input  write, write_reg, write_data,
        input  reserve, reserve_reg,
        output read_data1, read_data2,
        output read_pending1, read_pending2,
        output any_pending
    );

endinterface

// File: rtl/rf_read_port.sv
// One registered read port: range/zero checks, optional write bypass,
// and the data/pending output flops.
module rf_read_port
    import rf_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 4,
    parameter int BYPASS   = 0,
    parameter int ZERO_REG = 0,
    localparam int ADDR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] regs [DEPTH],
    input  logic [DEPTH-1:0]  pending,
    input  logic              w_ok,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic              r_ok,
    input  logic [ADDR_W-1:0] reserve_reg,
    output logic [DATA_W-1:0] data,
    output logic              pend
);

    localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);

    logic              in_range;
    logic              is_zero;
    logic              hit;
    logic [DATA_W-1:0] data_nxt;
    logic              pend_nxt;

    assign in_range = {1'b0, addr} < LIMIT;
    assign is_zero  = (ZERO_REG != 0)
                   && (addr == ADDR_W'(RF_ZERO_IDX));
    assign hit      = (BYPASS != 0) && w_ok
                   && (write_reg == addr);

    // A bypassed read sees the post-edge pending bit:
    // cleared by the write unless re-reserved this cycle.
    always_comb begin
        data_nxt = '0;
        pend_nxt = 1'b0;
        if (in_range && !is_zero) begin
            if (hit) begin
                data_nxt = write_data;
                pend_nxt = r_ok && (reserve_reg == addr);
            end else begin
                data_nxt = regs[addr];
                pend_nxt = pending[addr];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data <= '0;
            pend <= 1'b0;
        end else begin
            data <= data_nxt;
            pend <= pend_nxt;
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with per-register pending scoreboard for multi-cycle producers.
// Storage, write path and scoreboard live here; two rf_read_port instances.
module regfile_scoreboard
    import rf_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 4,
    parameter int BYPASS   = 0,
    parameter int ZERO_REG = 0
) (
    input logic clk,
    input logic reset,
    regfile_scoreboard_if.slave bus
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  pending;
    logic [DEPTH-1:0]  pending_nxt;
    logic              w_ok;
    logic              r_ok;

    assign w_ok = bus.write
               && ({1'b0, bus.write_reg} < LIMIT)
               && !((ZERO_REG != 0)
                    && (bus.write_reg == ADDR_W'(RF_ZERO_IDX)));

    assign r_ok = bus.reserve
               && ({1'b0, bus.reserve_reg} < LIMIT)
               && !((ZERO_REG != 0)
                    && (bus.reserve_reg == ADDR_W'(RF_ZERO_IDX)));

    // Reserve is applied after write so a new producer wins.
    always_comb begin
        pending_nxt = pending;
        if (w_ok) pending_nxt[bus.write_reg] = 1'b0;
        if (r_ok) pending_nxt[bus.reserve_reg] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
            pending <= '0;
        end else begin
            if (w_ok) regs[bus.write_reg] <= bus.write_data;
            pending <= pending_nxt;
        end
    end

    assign bus.any_pending = |pending;

    rf_read_port #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .BYPASS   (BYPASS),
        .ZERO_REG (ZERO_REG)
    ) u_rp1 (
        .clk         (clk),
        .reset       (reset),
        .addr        (bus.read_reg1),
        .regs        (regs),
        .pending     (pending),
        .w_ok        (w_ok),
        .write_reg   (bus.write_reg),
        .write_data  (bus.write_data),
        .r_ok        (r_ok),
        .reserve_reg (bus.reserve_reg),
        .data        (bus.read_data1),
        .pend        (bus.read_pending1)
    );

    rf_read_port #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .BYPASS   (BYPASS),
        .ZERO_REG (ZERO_REG)
    ) u_rp2 (
        .clk         (clk),
        .reset       (reset),
        .addr        (bus.read_reg2),
        .regs        (regs),
        .pending     (pending),
        .w_ok        (w_ok),
        .write_reg   (bus.write_reg),
        .write_data  (bus.write_data),
        .r_ok        (r_ok),
        .reserve_reg (bus.reserve_reg),
        .data        (bus.read_data2),
        .pend        (bus.read_pending2)
    );

endmodule
